pid_calc: RTL

PID_CALC -- requirements
Module: pid_calc

---
 rtl/pid_calc_if.sv | 26 ++
 rtl/pid_calc.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pid_calc_if.sv
// Request/response bundle for pid_calc: operands and gains in, saturated control output back.
interface pid_calc_if;
  localparam int unsigned W = 32;

  logic                start;
  logic                clr;
  logic signed [W-1:0] error;
  logic signed [W-1:0] error1;
  logic signed [W-1:0] sum_e;
  logic signed [W-1:0] kp;
  logic signed [W-1:0] ki;
  logic signed [W-1:0] kd;
  logic signed [W-1:0] u;
  logic                u_valid;
  logic                busy;

  modport master (
    output start, clr, error, error1, sum_e, kp, ki, kd,
    input  u, u_valid, busy
  );

  modport slave (
    input  start, clr, error, error1, sum_e, kp, ki, kd,
    output u, u_valid, busy
  );
endinterface

// File: rtl/pid_calc.sv
// Sequential PID output calculator: one shared multiplier walks P, I and D terms into a wide
// accumulator, then the Q-format result is floor-shifted and saturated into u.
module pid_calc #(
  parameter int unsigned        FRAC    = 16,
  parameter logic signed [31:0] OUT_MAX = 32'sd1000000,
  parameter logic signed [31:0] OUT_MIN = -32'sd1000000
) (
  input logic       clk,
  input logic       rstn,
  pid_calc_if.slave bus
);
  localparam int unsigned W    = 32;
  localparam int unsigned DW   = W + 1;
  localparam int unsigned PW   = DW + W;
  localparam int unsigned AW   = 67;
  localparam logic signed [AW-1:0] MAX_W = AW'(OUT_MAX);
  localparam logic signed [AW-1:0] MIN_W = AW'(OUT_MIN);

  typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D, SAT} state_e;

  state_e               state_q, state_d;
  logic signed [W-1:0]  e_q, e_d, e1_q, e1_d, s_q, s_d;
  logic signed [W-1:0]  kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [W-1:0]  u_q, u_d;
  logic                 u_valid_q, u_valid_d;
  logic                 busy_q, busy_d;

  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] mul_a;
  logic signed [W-1:0]  mul_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_sh;
  logic signed [W-1:0]  u_sat;

  // 33-bit difference cannot wrap, so extreme e/e1 pairs keep their true sign.
  assign diff = DW'(e1_q) == DW'(e_q) ? '0 : DW'(e_q) - DW'(e1_q);

  // The single multiplier; operands are steered by the current MUL state.
  always_comb begin
    mul_a = DW'(kp_q);
    mul_b = e_q;
    unique case (state_q)
      MUL_I:   begin mul_a = DW'(ki_q); mul_b = s_q;  end
      MUL_D:   begin mul_a = diff;      mul_b = kd_q; end
      default: begin mul_a = DW'(kp_q); mul_b = e_q;  end
    endcase
  end

  assign prod   = PW'(mul_a) * PW'(mul_b);
  assign acc_sh = acc_q >>> FRAC;

  // Clamp the full-width shifted accumulator into the output range.
  always_comb begin
    if (acc_sh > MAX_W)      u_sat = OUT_MAX;
    else if (acc_sh < MIN_W) u_sat = OUT_MIN;
    else                     u_sat = W'(acc_sh);
  end

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    e1_d      = e1_q;
    s_d       = s_q;
    kp_d      = kp_q;
    ki_d      = ki_q;
    kd_d      = kd_q;
    acc_d     = acc_q;
    u_d       = u_q;
    u_valid_d = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            e_d     = bus.error;
            e1_d    = bus.error1;
            s_d     = bus.sum_e;
            kp_d    = bus.kp;
            ki_d    = bus.ki;
            kd_d    = bus.kd;
            state_d = MUL_P;
          end
        end
        MUL_P: begin
          acc_d   = AW'(prod);
          state_d = MUL_I;
        end
        MUL_I: begin
          acc_d   = acc_q + AW'(prod);
          state_d = MUL_D;
        end
        MUL_D: begin
          acc_d   = acc_q + AW'(prod);
          state_d = SAT;
        end
        SAT: begin
          u_d       = u_sat;
          u_valid_d = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      e_q       <= '0;
      e1_q      <= '0;
      s_q       <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      acc_q     <= '0;
      u_q       <= '0;
      u_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      e1_q      <= e1_d;
      s_q       <= s_d;
      kp_q      <= kp_d;
      ki_q      <= ki_d;
      kd_q      <= kd_d;
      acc_q     <= acc_d;
      u_q       <= u_d;
      u_valid_q <= u_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.u       = u_q;
  assign bus.u_valid = u_valid_q;
  assign bus.busy    = busy_q;
endmodule
